control_unit: RTL and testbench



---
 rtl/xdn_pkg.sv | 51 +++++
 rtl/control_decoder.sv | 94 +++++++++
 rtl/control_unit.sv | 96 +++++++++
 tb/tb_control_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/xdn_pkg.sv
// Shared definitions for the bus CPU sequencer: opcodes, T-state numbers and
// the bit layout of the active-high control word produced by the decoder.
package xdn_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam int STEP_WIDTH   = 3;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'h5;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'h6;
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 4'h7;
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'h8;
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

  localparam logic [STEP_WIDTH-1:0] T0 = 3'd0;
  localparam logic [STEP_WIDTH-1:0] T1 = 3'd1;
  localparam logic [STEP_WIDTH-1:0] T2 = 3'd2;
  localparam logic [STEP_WIDTH-1:0] T3 = 3'd3;
  localparam logic [STEP_WIDTH-1:0] T4 = 3'd4;

  // Control word bits are active-high; the top level inverts the _n strobes.
  localparam int CW_PC_WRITE     = 0;
  localparam int CW_PC_JUMP      = 1;
  localparam int CW_PC_COUNT     = 2;
  localparam int CW_MAR_READ     = 3;
  localparam int CW_RAM_READ     = 4;
  localparam int CW_RAM_WRITE    = 5;
  localparam int CW_IR_READ      = 6;
  localparam int CW_IR_WRITE     = 7;
  localparam int CW_A_READ       = 8;
  localparam int CW_A_WRITE      = 9;
  localparam int CW_B_READ       = 10;
  localparam int CW_ALU_WRITE    = 11;
  localparam int CW_ALU_SUBTRACT = 12;
  localparam int CW_FLAGS_UPDATE = 13;
  localparam int CW_OUT_READ     = 14;
  localparam int CW_WIDTH        = 15;

  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

  typedef enum logic {
    MODE_RUN,
    MODE_HALTED
  } mode_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational microcode: maps (step, opcode, flags) to the control word,
// the end-of-instruction marker and the halt request.
module control_decoder
  import xdn_pkg::*;
(
  input  logic [STEP_WIDTH-1:0]   step,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero_flag,
  input  logic                    carry_flag,
  output ctrl_word_t              ctrl,
  output logic                    done,
  output logic                    halt
);

  always_comb begin
    ctrl = '0;
    done = 1'b0;
    halt = 1'b0;
    case (step)
      T0: begin
        ctrl[CW_PC_WRITE] = 1'b1;
        ctrl[CW_MAR_READ] = 1'b1;
      end
      T1: begin
        ctrl[CW_RAM_WRITE] = 1'b1;
        ctrl[CW_IR_READ]   = 1'b1;
        ctrl[CW_PC_COUNT]  = 1'b1;
      end
      T2: begin
        done = 1'b1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl[CW_IR_WRITE] = 1'b1;
            ctrl[CW_MAR_READ] = 1'b1;
            done = 1'b0;
          end
          OP_LDI: begin
            ctrl[CW_IR_WRITE] = 1'b1;
            ctrl[CW_A_READ]   = 1'b1;
          end
          OP_JMP: begin
            ctrl[CW_IR_WRITE] = 1'b1;
            ctrl[CW_PC_JUMP]  = 1'b1;
          end
          OP_JC: begin
            ctrl[CW_IR_WRITE] = carry_flag;
            ctrl[CW_PC_JUMP]  = carry_flag;
          end
          OP_JZ: begin
            ctrl[CW_IR_WRITE] = zero_flag;
            ctrl[CW_PC_JUMP]  = zero_flag;
          end
          OP_OUT: begin
            ctrl[CW_A_WRITE]  = 1'b1;
            ctrl[CW_OUT_READ] = 1'b1;
          end
          OP_HLT: halt = 1'b1;
          default: ;
        endcase
      end
      // An opcode that changes after T2 simply ends the instruction here.
      T3: begin
        done = 1'b1;
        case (opcode)
          OP_LDA: begin
            ctrl[CW_RAM_WRITE] = 1'b1;
            ctrl[CW_A_READ]    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl[CW_RAM_WRITE] = 1'b1;
            ctrl[CW_B_READ]    = 1'b1;
            done = 1'b0;
          end
          OP_STA: begin
            ctrl[CW_A_WRITE] = 1'b1;
            ctrl[CW_RAM_READ] = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        done = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl[CW_ALU_WRITE]    = 1'b1;
          ctrl[CW_A_READ]       = 1'b1;
          ctrl[CW_FLAGS_UPDATE] = 1'b1;
          ctrl[CW_ALU_SUBTRACT] = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// T-state sequencer for the bus CPU: owns the step counter and halted mode,
// and turns the decoder's control word into masked, active-low port strobes.
module control_unit
  import xdn_pkg::*;
#(
  parameter int OPCODE_WIDTH = xdn_pkg::OPCODE_WIDTH,
  parameter int STEP_WIDTH   = xdn_pkg::STEP_WIDTH
) (
  input  logic                    i_CLOCK,
  input  logic                    i_CLEAR,
  input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
  input  logic                    i_ZERO_FLAG,
  input  logic                    i_CARRY_FLAG,
  output logic                    o_PC_WRITE_BUS_n,
  output logic                    o_PC_JUMP_n,
  output logic                    o_PC_COUNT_ENABLE,
  output logic                    o_MAR_READ_BUS_n,
  output logic                    o_RAM_READ_BUS_n,
  output logic                    o_RAM_WRITE_BUS_n,
  output logic                    o_IR_READ_BUS_n,
  output logic                    o_IR_WRITE_BUS_n,
  output logic                    o_A_READ_BUS_n,
  output logic                    o_A_WRITE_BUS_n,
  output logic                    o_B_READ_BUS_n,
  output logic                    o_ALU_WRITE_BUS_n,
  output logic                    o_ALU_SUBTRACT,
  output logic                    o_FLAGS_UPDATE_n,
  output logic                    o_OUT_READ_BUS,
  output logic                    o_CLOCK_HALT,
  output logic [STEP_WIDTH-1:0]   o_STEP,
  output logic                    o_INSTR_DONE
);

  mode_t                 mode, mode_next;
  logic [STEP_WIDTH-1:0] step, step_next;
  ctrl_word_t            ctrl, cw;
  logic                  done, halt, running;

  control_decoder u_decoder (
    .step       (step),
    .opcode     (i_OPCODE),
    .zero_flag  (i_ZERO_FLAG),
    .carry_flag (i_CARRY_FLAG),
    .ctrl       (ctrl),
    .done       (done),
    .halt       (halt)
  );

  always_ff @(posedge i_CLOCK) begin
    if (i_CLEAR) begin
      step <= T0;
      mode <= MODE_RUN;
    end else begin
      step <= step_next;
      mode <= mode_next;
    end
  end

  // Steps past T4 can only come from upsets; they fall back to T0.
  always_comb begin
    step_next = step;
    mode_next = mode;
    if (mode == MODE_HALTED) begin
      step_next = T0;
    end else if (done || step >= T4) begin
      step_next = T0;
      if (halt) mode_next = MODE_HALTED;
    end else begin
      step_next = step + STEP_WIDTH'(1);
    end
  end

  assign running = !i_CLEAR && (mode == MODE_RUN);
  assign cw      = running ? ctrl : '0;

  assign o_PC_WRITE_BUS_n  = ~cw[CW_PC_WRITE];
  assign o_PC_JUMP_n       = ~cw[CW_PC_JUMP];
  assign o_PC_COUNT_ENABLE =  cw[CW_PC_COUNT];
  assign o_MAR_READ_BUS_n  = ~cw[CW_MAR_READ];
  assign o_RAM_READ_BUS_n  = ~cw[CW_RAM_READ];
  assign o_RAM_WRITE_BUS_n = ~cw[CW_RAM_WRITE];
  assign o_IR_READ_BUS_n   = ~cw[CW_IR_READ];
  assign o_IR_WRITE_BUS_n  = ~cw[CW_IR_WRITE];
  assign o_A_READ_BUS_n    = ~cw[CW_A_READ];
  assign o_A_WRITE_BUS_n   = ~cw[CW_A_WRITE];
  assign o_B_READ_BUS_n    = ~cw[CW_B_READ];
  assign o_ALU_WRITE_BUS_n = ~cw[CW_ALU_WRITE];
  assign o_ALU_SUBTRACT    =  cw[CW_ALU_SUBTRACT];
  assign o_FLAGS_UPDATE_n  = ~cw[CW_FLAGS_UPDATE];
  assign o_OUT_READ_BUS    =  cw[CW_OUT_READ];

  assign o_CLOCK_HALT = !i_CLEAR && (mode == MODE_HALTED);
  assign o_STEP       = running ? step : '0;
  assign o_INSTR_DONE = running && done;

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against an instruction-level
// model (instruction lengths plus per-step micro-operation lists).
module tb_control_unit;

  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] opcode;
  logic       zero, carry;
  logic       pc_write_n, pc_jump_n, pc_count, mar_read_n, ram_read_n, ram_write_n;
  logic       ir_read_n, ir_write_n, a_read_n, a_write_n, b_read_n, alu_write_n;
  logic       alu_sub, flags_n, out_read, clock_halt, instr_done;
  logic [2:0] step_obs;

  int checks   = 0;
  int failures = 0;

  int m_step   = 0;
  bit m_halted = 1'b0;

  // Bench-local strobe order (active-high).
  localparam int S_PCW = 0, S_PCJ = 1, S_PCC = 2, S_MAR = 3, S_RAMR = 4,
                 S_RAMW = 5, S_IRR = 6, S_IRW = 7, S_AR = 8, S_AW = 9,
                 S_BR = 10, S_ALUW = 11, S_SUB = 12, S_FLG = 13, S_OUT = 14;

  control_unit dut (
    .i_CLOCK           (clock),
    .i_CLEAR           (clear),
    .i_OPCODE          (opcode),
    .i_ZERO_FLAG       (zero),
    .i_CARRY_FLAG      (carry),
    .o_PC_WRITE_BUS_n  (pc_write_n),
    .o_PC_JUMP_n       (pc_jump_n),
    .o_PC_COUNT_ENABLE (pc_count),
    .o_MAR_READ_BUS_n  (mar_read_n),
    .o_RAM_READ_BUS_n  (ram_read_n),
    .o_RAM_WRITE_BUS_n (ram_write_n),
    .o_IR_READ_BUS_n   (ir_read_n),
    .o_IR_WRITE_BUS_n  (ir_write_n),
    .o_A_READ_BUS_n    (a_read_n),
    .o_A_WRITE_BUS_n   (a_write_n),
    .o_B_READ_BUS_n    (b_read_n),
    .o_ALU_WRITE_BUS_n (alu_write_n),
    .o_ALU_SUBTRACT    (alu_sub),
    .o_FLAGS_UPDATE_n  (flags_n),
    .o_OUT_READ_BUS    (out_read),
    .o_CLOCK_HALT      (clock_halt),
    .o_STEP            (step_obs),
    .o_INSTR_DONE      (instr_done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int instrLength(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [14:0] bit1(input int idx);
    logic [14:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Micro-operations of each instruction, written straight from the opcode table.
  function automatic logic [14:0] microOps(input int st, input logic [3:0] op,
                                           input logic c, input logic z);
    if (st == 0) return bit1(S_PCW) | bit1(S_MAR);
    if (st == 1) return bit1(S_RAMW) | bit1(S_IRR) | bit1(S_PCC);
    case (op)
      4'h1: if (st == 2) return bit1(S_IRW) | bit1(S_MAR);
            else if (st == 3) return bit1(S_RAMW) | bit1(S_AR);
      4'h2, 4'h3:
            if (st == 2) return bit1(S_IRW) | bit1(S_MAR);
            else if (st == 3) return bit1(S_RAMW) | bit1(S_BR);
            else if (st == 4) return bit1(S_ALUW) | bit1(S_AR) | bit1(S_FLG)
                                     | (op == 4'h3 ? bit1(S_SUB) : 15'd0);
      4'h4: if (st == 2) return bit1(S_IRW) | bit1(S_MAR);
            else if (st == 3) return bit1(S_AW) | bit1(S_RAMR);
      4'h5: return bit1(S_IRW) | bit1(S_AR);
      4'h6: return bit1(S_IRW) | bit1(S_PCJ);
      4'h7: if (c) return bit1(S_IRW) | bit1(S_PCJ);
      4'h8: if (z) return bit1(S_IRW) | bit1(S_PCJ);
      4'hE: return bit1(S_AW) | bit1(S_OUT);
      default: ;
    endcase
    return '0;
  endfunction

  // One clock: drive inputs, check the settled outputs, advance the model.
  task automatic applyStimulus(input logic [3:0] op, input logic c, input logic z,
                               input logic clr);
    logic [14:0] exp_ops, obs_ops;
    logic        exp_done, exp_halt;
    int          exp_step, drivers;
    opcode = op; carry = c; zero = z; clear = clr;
    #2;
    exp_ops = '0; exp_done = 1'b0; exp_halt = 1'b0; exp_step = 0;
    if (!clr && m_halted) begin
      exp_halt = 1'b1;
    end else if (!clr) begin
      exp_ops  = microOps(m_step, op, c, z);
      exp_done = (m_step == instrLength(op) - 1);
      exp_step = m_step;
    end
    obs_ops = {out_read, ~flags_n, alu_sub, ~alu_write_n, ~b_read_n, ~a_write_n,
               ~a_read_n, ~ir_write_n, ~ir_read_n, ~ram_write_n, ~ram_read_n,
               ~mar_read_n, pc_count, ~pc_jump_n, ~pc_write_n};
    checkOutput($sformatf("strobes op=%0h T%0d clr=%0b", op, exp_step, clr),
                32'(obs_ops), 32'(exp_ops));
    checkOutput("step", 32'(step_obs), 32'(exp_step));
    checkOutput("instr_done", 32'(instr_done), 32'(exp_done));
    checkOutput("clock_halt", 32'(clock_halt), 32'(exp_halt));
    drivers = int'(~pc_write_n) + int'(~ram_write_n) + int'(~ir_write_n)
            + int'(~a_write_n) + int'(~alu_write_n);
    checkOutput("one_bus_driver", 32'(drivers <= 1), 32'd1);
    @(posedge clock);
    if (clr) begin
      m_step = 0; m_halted = 1'b0;
    end else if (!m_halted) begin
      if (exp_done) begin
        m_step = 0;
        if (op == 4'hF) m_halted = 1'b1;
      end else begin
        m_step++;
      end
    end
    #1;
  endtask

  task automatic runInstr(input logic [3:0] op, input logic c, input logic z);
    do applyStimulus(op, c, z, 1'b0); while (m_step != 0);
  endtask

  initial begin
    logic [3:0] op;
    clear = 1'b1; opcode = '0; zero = 1'b0; carry = 1'b0;
    @(posedge clock); #1;
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b1);

    runInstr(4'h2, 1'b0, 1'b0);
    repeat (3) applyStimulus(4'h2, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h2, 1'b0, 1'b0, 1'b1);
    runInstr(4'h3, 1'b1, 1'b1);
    runInstr(4'h7, 1'b0, 1'b1);
    runInstr(4'h7, 1'b1, 1'b0);
    runInstr(4'h8, 1'b0, 1'b1);
    runInstr(4'h5, 1'b0, 1'b0);
    runInstr(4'hE, 1'b0, 1'b0);
    runInstr(4'hB, 1'b1, 1'b1);
    runInstr(4'h1, 1'b0, 1'b0);
    runInstr(4'h4, 1'b0, 1'b0);
    runInstr(4'hF, 1'b0, 1'b0);
    repeat (10) applyStimulus(4'(($urandom)), 1'($urandom), 1'($urandom), 1'b0);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom);
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 3)) applyStimulus(op, 1'($urandom), 1'($urandom), 1'b0);
        applyStimulus(op, 1'($urandom), 1'($urandom), 1'b1);
      end else begin
        do applyStimulus(op, 1'($urandom), 1'($urandom), 1'b0); while (m_step != 0);
      end
      if (m_halted) begin
        repeat ($urandom_range(1, 4)) applyStimulus(4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        applyStimulus(4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
